// File: rtl/clusterv_wb_openram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clusterv_wb_openram_pkg
// Description : Shared definitions for the Wishbone-to-OpenRAM target:
//               FSM state encoding and OpenRAM data/select widths.
// Revision    : 1.0 - initial release
// ============================================================================
package clusterv_wb_openram_pkg;

    localparam int OPENRAM_DAT_WIDTH = 32;
    localparam int OPENRAM_SEL_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_RDATA = 2'd2,
        ST_RESP  = 2'd3
    } wb_state_t;

endpackage : clusterv_wb_openram_pkg
`default_nettype wire

// File: rtl/clusterv_wb_openram_rdbuf.sv
`default_nettype none
// ============================================================================
// Module      : clusterv_wb_openram_rdbuf
// Description : One-entry last-read buffer (valid, word address, data).
//               Combinational hit compare against the lookup address, fill
//               on a completed SRAM read, invalidate on a write to the
//               buffered word.
// Ports       : clock, reset (async active-low)
//               lookup_addr -> hit / hit_data
//               fill_en, fill_addr, fill_data : load the entry
//               inv_en, inv_addr              : drop the entry if it matches
// Revision    : 1.0 - initial release
// ============================================================================
module clusterv_wb_openram_rdbuf
    import clusterv_wb_openram_pkg::*;
#(
    parameter int ADR_WIDTH = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [ADR_WIDTH-1:0]         lookup_addr,
    output logic                         hit,
    output logic [OPENRAM_DAT_WIDTH-1:0] hit_data,
    input  logic                         fill_en,
    input  logic [ADR_WIDTH-1:0]         fill_addr,
    input  logic [OPENRAM_DAT_WIDTH-1:0] fill_data,
    input  logic                         inv_en,
    input  logic [ADR_WIDTH-1:0]         inv_addr
);

    logic                         r_valid;
    logic [ADR_WIDTH-1:0]         r_addr;
    logic [OPENRAM_DAT_WIDTH-1:0] r_data;

    assign hit      = r_valid && (r_addr == lookup_addr);
    assign hit_data = r_data;

    // Fill and invalidate come from different FSM states, so they never
    // coincide; fill is given priority anyway for determinism.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else if (fill_en) begin
            r_valid <= 1'b1;
            r_addr  <= fill_addr;
            r_data  <= fill_data;
        end else if (inv_en && (inv_addr == r_addr)) begin
            r_valid <= 1'b0;
        end
    end

endmodule : clusterv_wb_openram_rdbuf
`default_nettype wire

// File: rtl/clusterv_wb_openram_target.sv
`default_nettype none
// ============================================================================
// Module      : clusterv_wb_openram_target
// Description : Wishbone (tagged, classic single cycle) target serving one
//               interconnect slot from a sky130 OpenRAM 1RW port. Range-checks
//               the offset below BASE_MASK, converts reads/writes into one
//               OpenRAM command cycle and returns a one-cycle ack or err.
//               Latency from the request cycle N: err N+1, write N+2,
//               read N+3 (read-buffer hit N+1).
// Config      : CLUSTERV_WB_OPENRAM_RDBUF_EN - adds a one-entry last-read
//               buffer; undefined builds have no buffer.
// Ports       : clock, reset (async active-low)
//               WB  : t_adr, t_dat_w, t_dat_r, t_cyc, t_stb, t_we, t_sel,
//                     t_ack, t_err, t_tgd_w/t_tga/t_tgc (ignored), t_tgd_r (0)
//               RAM : i_csb, i_web (active-low), i_wmask, i_addr, i_din,
//                     i_dout (valid the cycle after the command cycle)
// Revision    : 1.0 - initial release
// ============================================================================
module clusterv_wb_openram_target
    import clusterv_wb_openram_pkg::*;
#(
    parameter int          ADR_WIDTH = 8,
    parameter logic [31:0] BASE_MASK = 32'hFFF00000
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [31:0]                  t_adr,
    input  logic [OPENRAM_DAT_WIDTH-1:0] t_dat_w,
    output logic [OPENRAM_DAT_WIDTH-1:0] t_dat_r,
    input  logic                         t_cyc,
    input  logic                         t_stb,
    input  logic                         t_we,
    input  logic [OPENRAM_SEL_WIDTH-1:0] t_sel,
    output logic                         t_ack,
    output logic                         t_err,
    input  logic                         t_tgd_w,
    input  logic                         t_tga,
    input  logic [3:0]                   t_tgc,
    output logic                         t_tgd_r,
    output logic                         i_csb,
    output logic                         i_web,
    output logic [OPENRAM_SEL_WIDTH-1:0] i_wmask,
    output logic [ADR_WIDTH-1:0]         i_addr,
    output logic [OPENRAM_DAT_WIDTH-1:0] i_din,
    input  logic [OPENRAM_DAT_WIDTH-1:0] i_dout
);

    wb_state_t                    r_state;
    wb_state_t                    w_state_nxt;
    logic                         r_we;

    logic                         w_we_nxt;
    logic                         w_ack_nxt;
    logic                         w_err_nxt;
    logic [OPENRAM_DAT_WIDTH-1:0] w_dat_r_nxt;
    logic                         w_csb_nxt;
    logic                         w_web_nxt;
    logic [OPENRAM_SEL_WIDTH-1:0] w_wmask_nxt;
    logic [ADR_WIDTH-1:0]         w_addr_nxt;
    logic [OPENRAM_DAT_WIDTH-1:0] w_din_nxt;
    logic                         w_fill;
    logic                         w_inv;
    logic                         w_buf_hit;
    logic [OPENRAM_DAT_WIDTH-1:0] w_buf_data;

    // Bits under BASE_MASK were decoded upstream; anything left above the
    // word-address field falls outside this RAM's window.
    logic [31:0]                  w_offset;
    logic                         w_out_of_range;
    logic [ADR_WIDTH-1:0]         w_word;

    assign w_offset       = t_adr & ~BASE_MASK;
    assign w_out_of_range = |(w_offset >> (ADR_WIDTH + 2));
    assign w_word         = t_adr[ADR_WIDTH+1:2];
    assign t_tgd_r        = 1'b0;

    // Tags and the byte-offset bits carry no meaning for this target.
    logic w_unused_ok;
    assign w_unused_ok = ^{t_tgd_w, t_tga, t_tgc, t_adr[1:0]};

`ifdef CLUSTERV_WB_OPENRAM_RDBUF_EN
    clusterv_wb_openram_rdbuf #(
        .ADR_WIDTH (ADR_WIDTH)
    ) u_rdbuf (
        .clock       (clock),
        .reset       (reset),
        .lookup_addr (w_word),
        .hit         (w_buf_hit),
        .hit_data    (w_buf_data),
        .fill_en     (w_fill),
        .fill_addr   (i_addr),
        .fill_data   (i_dout),
        .inv_en      (w_inv),
        .inv_addr    (w_word)
    );
`else
    assign w_buf_hit  = 1'b0;
    assign w_buf_data = '0;
    logic w_unused_nobuf;
    assign w_unused_nobuf = ^{w_fill, w_inv};
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_we_nxt    = r_we;
        w_ack_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_dat_r_nxt = t_dat_r;
        w_csb_nxt   = 1'b1;
        w_web_nxt   = 1'b1;
        w_wmask_nxt = '0;
        w_addr_nxt  = i_addr;
        w_din_nxt   = i_din;
        w_fill      = 1'b0;
        w_inv       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (t_cyc && t_stb) begin
                    if (w_out_of_range) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_RESP;
                    end else if (!t_we && w_buf_hit) begin
                        w_ack_nxt   = 1'b1;
                        w_dat_r_nxt = w_buf_data;
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_we_nxt    = t_we;
                        w_addr_nxt  = w_word;
                        w_din_nxt   = t_dat_w;
                        w_csb_nxt   = 1'b0;
                        w_web_nxt   = ~t_we;
                        w_wmask_nxt = t_we ? t_sel : '0;
                        w_inv       = t_we;
                        w_state_nxt = ST_CMD;
                    end
                end
            end
            // The SRAM samples the command at the end of this cycle, so a
            // dropped cycle cannot abort it; it only suppresses the response.
            ST_CMD: begin
                if (!t_cyc) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_we) begin
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_RDATA;
                end
            end
            ST_RDATA: begin
                if (!t_cyc) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_dat_r_nxt = i_dout;
                    w_fill      = 1'b1;
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_we    <= 1'b0;
            t_ack   <= 1'b0;
            t_err   <= 1'b0;
            t_dat_r <= '0;
            i_csb   <= 1'b1;
            i_web   <= 1'b1;
            i_wmask <= '0;
            i_addr  <= '0;
            i_din   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_we    <= w_we_nxt;
            t_ack   <= w_ack_nxt;
            t_err   <= w_err_nxt;
            t_dat_r <= w_dat_r_nxt;
            i_csb   <= w_csb_nxt;
            i_web   <= w_web_nxt;
            i_wmask <= w_wmask_nxt;
            i_addr  <= w_addr_nxt;
            i_din   <= w_din_nxt;
        end
    end

endmodule : clusterv_wb_openram_target
`default_nettype wire

// File: tb/tb_clusterv_wb_openram_target.sv
`default_nettype none
// ============================================================================
// Module      : tb_clusterv_wb_openram_target
// Description : Self-checking bench for clusterv_wb_openram_target. Drives
//               directed and random Wishbone transactions, models the
//               OpenRAM macro, and compares against a word-array reference
//               model (plus last-read tracking when the read buffer is built).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clusterv_wb_openram_target;

`ifdef CLUSTERV_WB_OPENRAM_RDBUF_EN
    localparam bit RDBUF = 1'b1;
`else
    localparam bit RDBUF = 1'b0;
`endif
    localparam logic [31:0] BASE_MASK = 32'hFFF00000;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] t_adr, t_dat_w, t_dat_r;
    logic        t_cyc, t_stb, t_we;
    logic [3:0]  t_sel;
    logic        t_ack, t_err;
    logic        t_tgd_w, t_tga, t_tgd_r;
    logic [3:0]  t_tgc;
    logic        i_csb, i_web;
    logic [3:0]  i_wmask;
    logic [7:0]  i_addr;
    logic [31:0] i_din, i_dout;

    always #5 clock = ~clock;

    clusterv_wb_openram_target #(
        .ADR_WIDTH (8),
        .BASE_MASK (BASE_MASK)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .t_adr   (t_adr),
        .t_dat_w (t_dat_w),
        .t_dat_r (t_dat_r),
        .t_cyc   (t_cyc),
        .t_stb   (t_stb),
        .t_we    (t_we),
        .t_sel   (t_sel),
        .t_ack   (t_ack),
        .t_err   (t_err),
        .t_tgd_w (t_tgd_w),
        .t_tga   (t_tga),
        .t_tgc   (t_tgc),
        .t_tgd_r (t_tgd_r),
        .i_csb   (i_csb),
        .i_web   (i_web),
        .i_wmask (i_wmask),
        .i_addr  (i_addr),
        .i_din   (i_din),
        .i_dout  (i_dout)
    );

    // OpenRAM 1RW macro: command sampled on the rising edge, read data
    // appears after that edge.
    logic [31:0] sram [256];
    always @(posedge clock) begin
        if (!i_csb) begin
            if (!i_web) begin
                for (int b = 0; b < 4; b++)
                    if (i_wmask[b]) sram[i_addr][8*b +: 8] <= i_din[8*b +: 8];
            end else begin
                i_dout <= sram[i_addr];
            end
        end
    end

    // Reference model
    logic [31:0] ref_mem [256];
    bit          buf_valid;
    logic [7:0]  buf_word;
    logic [31:0] exp_rdata;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel);
        bit          err_exp, hit;
        int          lat_exp, lat, ncs;
        logic [7:0]  wd;
        logic        got_ack, got_err;
        logic [31:0] obs_rdata;
        err_exp   = ((adr & ~BASE_MASK) >> 10) != 0;
        wd        = adr[9:2];
        hit       = RDBUF && !we && !err_exp && buf_valid && (buf_word == wd);
        lat_exp   = err_exp ? 1 : (we ? 2 : (hit ? 1 : 3));
        lat       = 0;
        ncs       = 0;
        got_ack   = 1'b0;
        got_err   = 1'b0;
        obs_rdata = 'x;

        @(negedge clock);
        t_cyc = 1'b1; t_stb = 1'b1; t_we = we; t_adr = adr; t_dat_w = dat; t_sel = sel;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clock); #1;
            if (!i_csb) begin
                ncs++;
                check("cmd_web",   32'(i_web),   32'(!we));
                check("cmd_wmask", 32'(i_wmask), we ? 32'(sel) : 32'd0);
                check("cmd_addr",  32'(i_addr),  32'(wd));
                if (we) check("cmd_din", i_din, dat);
            end
            if (t_ack || t_err) begin
                lat = k; got_ack = t_ack; got_err = t_err; obs_rdata = t_dat_r;
                break;
            end
        end
        t_cyc = 1'b0; t_stb = 1'b0;

        if (!err_exp) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (sel[b]) ref_mem[wd][8*b +: 8] = dat[8*b +: 8];
                if (buf_word == wd) buf_valid = 1'b0;
            end else begin
                exp_rdata = ref_mem[wd];
                buf_valid = 1'b1;
                buf_word  = wd;
            end
        end

        check("latency", 32'(lat), 32'(lat_exp));
        check("ack", 32'(got_ack), 32'(!err_exp));
        check("err", 32'(got_err), 32'(err_exp));
        check("sram_cmds", 32'(ncs), (err_exp || hit) ? 32'd0 : 32'd1);
        check("rdata", obs_rdata, exp_rdata);

        @(posedge clock); #1;
        check("resp_one_cycle", 32'({t_ack, t_err}), 32'd0);
    endtask

    initial begin
        logic [31:0] off, adr;
        reset = 1'b0;
        t_cyc = 0; t_stb = 0; t_we = 0; t_adr = 0; t_dat_w = 0; t_sel = 0;
        t_tgd_w = 0; t_tga = 0; t_tgc = 0;
        for (int i = 0; i < 256; i++) begin
            sram[i]    = $urandom;
            ref_mem[i] = sram[i];
        end
        buf_valid = 1'b0; buf_word = 8'd0; exp_rdata = 32'd0;

        repeat (3) @(posedge clock);
        #1;
        check("rst_ack",   32'(t_ack),   32'd0);
        check("rst_err",   32'(t_err),   32'd0);
        check("rst_dat_r", t_dat_r,      32'd0);
        check("rst_tgd_r", 32'(t_tgd_r), 32'd0);
        check("rst_csb",   32'(i_csb),   32'd1);
        check("rst_web",   32'(i_web),   32'd1);
        check("rst_wmask", 32'(i_wmask), 32'd0);
        check("rst_addr",  32'(i_addr),  32'd0);
        check("rst_din",   i_din,        32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Directed
        do_req(1'b1, 32'h80000010, 32'hDEADBEEF, 4'hF);
        do_req(1'b0, 32'h80000010, 32'h0, 4'hF);
        check("dir_readback", t_dat_r, 32'hDEADBEEF);
        do_req(1'b0, 32'h80000010, 32'h0, 4'hF);
        do_req(1'b1, 32'h80000010, 32'h0000AA00, 4'h2);
        do_req(1'b0, 32'h80000010, 32'h0, 4'hF);
        check("dir_merge", t_dat_r, 32'hDEADAAEF);
        do_req(1'b0, 32'h80000400, 32'h0, 4'hF);
        do_req(1'b1, 32'h80000014, 32'h12345678, 4'h0);
        do_req(1'b0, 32'h80000017, 32'h0, 4'hF);
        do_req(1'b0, 32'h800003FC, 32'h0, 4'hF);

        // Random: small word set so reads repeat, some out-of-range offsets
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 7) == 0)
                off = 32'h400 + 32'($urandom_range(0, 32'hFF000));
            else
                off = 32'(($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
            adr = ($urandom & BASE_MASK) | off;
            do_req(1'($urandom_range(0, 1)), adr, $urandom, 4'($urandom_range(0, 15)));
        end

        // Drop t_cyc while the read data is returning
        @(negedge clock);
        t_cyc = 1; t_stb = 1; t_we = 0; t_adr = 32'h80000020; t_sel = 4'hF;
        if (RDBUF && buf_valid && buf_word == 8'd8) begin
            // force a miss on word 8 so the read reaches RDATA
            t_cyc = 0; t_stb = 0;
            do_req(1'b1, 32'h80000020, $urandom, 4'h0);
            @(negedge clock);
            t_cyc = 1; t_stb = 1; t_we = 0; t_adr = 32'h80000020; t_sel = 4'hF;
        end
        @(posedge clock); #1;
        check("abort_cmd_csb", 32'(i_csb), 32'd0);
        @(posedge clock); #1;
        t_cyc = 0; t_stb = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            check("abort_no_resp", 32'({t_ack, t_err}), 32'd0);
        end
        do_req(1'b1, 32'h80000020, 32'hA5A5_0F0F, 4'hF);
        do_req(1'b0, 32'h80000020, 32'h0, 4'hF);

        // Reset during the command cycle of a read
        @(negedge clock);
        t_cyc = 1; t_stb = 1; t_we = 0; t_adr = 32'h80000024; t_sel = 4'hF;
        @(posedge clock); #1;
        check("midrst_csb_before", 32'(i_csb), 32'd0);
        reset = 1'b0;
        #1;
        check("midrst_csb_async", 32'(i_csb), 32'd1);
        check("midrst_dat_r", t_dat_r, 32'd0);
        t_cyc = 0; t_stb = 0;
        buf_valid = 1'b0; exp_rdata = 32'd0;
        @(posedge clock); #1;
        check("midrst_ack", 32'({t_ack, t_err}), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        do_req(1'b0, 32'h80000024, 32'h0, 4'hF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule : tb_clusterv_wb_openram_target
`default_nettype wire
